// File: rtl/axi4_mem_slave_if.sv
// ifc_axi4: full AXI4 link bundle with master and slave views.
// Carries its own clk/rst_n for agents that want them.
interface ifc_axi4 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
) (
  input logic clk,
  input logic rst_n
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [3:0]            awregion;
  logic                  awvalid;
  logic                  awready;

  logic [ID_WIDTH-1:0]   wid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic [USER_WIDTH-1:0] buser;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [USER_WIDTH-1:0] ruser;
  logic                  rvalid;
  logic                  rready;

  modport master (
    input  clk, rst_n,
    output awid, awaddr, awlen, awsize, awburst, awlock,
    output awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock,
    output arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  clk, rst_n,
    input  awid, awaddr, awlen, awsize, awburst, awlock,
    input  awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock,
    input  arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 slave over an internal word memory.
// Define AXI4_MEM_SLAVE_WSTRB_EN for byte-lane write strobes.
module axi4_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input logic    clk,
  input logic    rst,
  ifc_axi4.slave s_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF = $clog2(STRB_WIDTH);
  localparam int MW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRB_WIDTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wstate_t               wstate, wstate_nx;
  logic [ID_WIDTH-1:0]   wid_q;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [7:0]            wlen, wcnt;
  logic [1:0]            wburst;
  logic                  wbad, werr;

  rstate_t               rstate, rstate_nx;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [7:0]            rlen, rcnt;
  logic [1:0]            rburst;
  logic                  rbad, rerr;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic live;
  logic aw_hs, w_hs, ar_hs, r_hs;
  logic win, rin, wfin, rfin, mem_we;
  logic [MW-1:0] widx, ridx;

  // WRAP, reserved bursts and non-native sizes poison the burst
  function automatic logic bad_burst(
    input logic [1:0] b,
    input logic [2:0] sz
  );
    return b[1] || (sz != 3'(OFF));
  endfunction

  assign win  = waddr[ADDR_WIDTH-1:OFF+MW] == '0;
  assign rin  = raddr[ADDR_WIDTH-1:OFF+MW] == '0;
  assign widx = waddr[OFF+MW-1:OFF];
  assign ridx = raddr[OFF+MW-1:OFF];
  assign wfin = wcnt == wlen;
  assign rfin = rcnt == rlen;

  assign aw_hs  = (wstate == W_IDLE) && live && s_axi.awvalid;
  assign w_hs   = (wstate == W_DATA) && s_axi.wvalid;
  assign ar_hs  = (rstate == R_IDLE) && live && s_axi.arvalid;
  assign r_hs   = (rstate == R_DATA) && s_axi.rready;
  assign mem_we = w_hs && win && !wbad;

  // Holds the readies low for the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  // Write state and captured AW context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate <= W_IDLE;
      wid_q  <= '0;
      waddr  <= '0;
      wlen   <= '0;
      wcnt   <= '0;
      wburst <= '0;
      wbad   <= 1'b0;
      werr   <= 1'b0;
    end else begin
      wstate <= wstate_nx;
      if (aw_hs) begin
        wid_q  <= s_axi.awid;
        waddr  <= s_axi.awaddr;
        wlen   <= s_axi.awlen;
        wburst <= s_axi.awburst;
        wcnt   <= '0;
        wbad   <= bad_burst(s_axi.awburst, s_axi.awsize);
        werr   <= bad_burst(s_axi.awburst, s_axi.awsize);
      end else if (w_hs) begin
        wcnt <= wcnt + 8'd1;
        if (wburst == 2'b01) waddr <= waddr + STEP;
        if (!win || (s_axi.wlast != wfin)) werr <= 1'b1;
      end
    end
  end

  // Write next-state and AW/W/B outputs
  always_comb begin
    wstate_nx     = wstate;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bid     = '0;
    s_axi.bresp   = 2'b00;
    s_axi.buser   = '0;
    unique case (wstate)
      W_IDLE: begin
        s_axi.awready = live;
        if (aw_hs) wstate_nx = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (w_hs && wfin) wstate_nx = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        s_axi.bid    = wid_q;
        s_axi.bresp  = {werr, 1'b0};
        if (s_axi.bready) wstate_nx = W_IDLE;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef AXI4_MEM_SLAVE_WSTRB_EN
      for (int i = 0; i < STRB_WIDTH; i++)
        if (s_axi.wstrb[i])
          mem[widx][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
`else
      mem[widx] <= s_axi.wdata;
`endif
    end
  end

  // Read state, captured AR context and registered beat data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate  <= R_IDLE;
      rid_q   <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rcnt    <= '0;
      rburst  <= '0;
      rbad    <= 1'b0;
      rerr    <= 1'b0;
      rdata_q <= '0;
    end else begin
      rstate <= rstate_nx;
      if (ar_hs) begin
        rid_q  <= s_axi.arid;
        raddr  <= s_axi.araddr;
        rlen   <= s_axi.arlen;
        rburst <= s_axi.arburst;
        rcnt   <= '0;
        rbad   <= bad_burst(s_axi.arburst, s_axi.arsize);
      end
      if (rstate == R_FETCH) begin
        rdata_q <= (rin && !rbad) ? mem[ridx] : '0;
        rerr    <= !rin || rbad;
      end
      if (r_hs && !rfin) begin
        rcnt <= rcnt + 8'd1;
        if (rburst == 2'b01) raddr <= raddr + STEP;
      end
    end
  end

  // Read next-state and AR/R outputs
  always_comb begin
    rstate_nx     = rstate;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rid     = '0;
    s_axi.rdata   = '0;
    s_axi.rresp   = 2'b00;
    s_axi.rlast   = 1'b0;
    s_axi.ruser   = '0;
    unique case (rstate)
      R_IDLE: begin
        s_axi.arready = live;
        if (ar_hs) rstate_nx = R_FETCH;
      end
      R_FETCH: rstate_nx = R_DATA;
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        s_axi.rid    = rid_q;
        s_axi.rdata  = rdata_q;
        s_axi.rresp  = {rerr, 1'b0};
        s_axi.rlast  = rfin;
        if (r_hs) rstate_nx = rfin ? R_IDLE : R_FETCH;
      end
      default: rstate_nx = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: directed vector bench for axi4_mem_slave.
// Vector table plus hand sequences for latency and reset abort.
module tb_axi4_mem_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifc_axi4 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4))
    s_axi (.clk(clk), .rst_n(~rst));

  axi4_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ID_WIDTH(4), .MEM_DEPTH(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axi(s_axi.slave)
  );

`ifdef AXI4_MEM_SLAVE_WSTRB_EN
  localparam logic [31:0] STRB_EXP = 32'hFF34FF78;
`else
  localparam logic [31:0] STRB_EXP = 32'h12345678;
`endif

  typedef struct {
    bit               wr;
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [2:0]       size;
    logic [31:0]      base;
    logic [3:0]       strb;
    int               early;
    logic [1:0]       exp_b;
    logic [3:0][31:0] exp_d;
    logic [3:0][1:0]  exp_r;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mkw(
    input logic [3:0] id, input logic [31:0] addr,
    input logic [7:0] len, input logic [1:0] burst,
    input logic [2:0] size, input logic [31:0] base,
    input logic [3:0] strb, input int early,
    input logic [1:0] exp_b
  );
    vec_t v;
    v.wr = 1'b1; v.id = id; v.addr = addr; v.len = len;
    v.burst = burst; v.size = size; v.base = base;
    v.strb = strb; v.early = early; v.exp_b = exp_b;
    v.exp_d = '0; v.exp_r = '0;
    return v;
  endfunction

  function automatic vec_t mkr(
    input logic [3:0] id, input logic [31:0] addr,
    input logic [7:0] len, input logic [1:0] burst,
    input logic [3:0][31:0] d, input logic [3:0][1:0] r
  );
    vec_t v;
    v.wr = 1'b0; v.id = id; v.addr = addr; v.len = len;
    v.burst = burst; v.size = 3'd2; v.base = '0;
    v.strb = '0; v.early = -1; v.exp_b = '0;
    v.exp_d = d; v.exp_r = r;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input vec_t v, input string nm,
                           output logic [1:0] resp,
                           output logic [3:0] id);
    bit ok;
    resp = 'x;
    id = 'x;
    s_axi.awid = v.id;
    s_axi.awaddr = v.addr;
    s_axi.awlen = v.len;
    s_axi.awsize = v.size;
    s_axi.awburst = v.burst;
    s_axi.awvalid = 1'b1;
    ok = 0;
    for (int n = 0; n < 64; n++) begin
      if (s_axi.awready) begin ok = 1; tick(); break; end
      tick();
    end
    s_axi.awvalid = 1'b0;
    chk({nm, "_aw_hs"}, 32'(ok), 1);
    for (int i = 0; i <= int'(v.len); i++) begin
      s_axi.wdata = v.base + i;
      s_axi.wstrb = v.strb;
      s_axi.wlast = (v.early >= 0) ? (i == v.early)
                                   : (i == int'(v.len));
      s_axi.wvalid = 1'b1;
      ok = 0;
      for (int n = 0; n < 64; n++) begin
        if (s_axi.wready) begin ok = 1; tick(); break; end
        tick();
      end
      if (!ok) chk($sformatf("%s_w%0d_hs", nm, i), 32'(ok), 1);
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast = 1'b0;
    s_axi.bready = 1'b1;
    ok = 0;
    for (int n = 0; n < 64; n++) begin
      if (s_axi.bvalid) begin
        ok = 1;
        resp = s_axi.bresp;
        id = s_axi.bid;
        tick();
        break;
      end
      tick();
    end
    s_axi.bready = 1'b0;
    chk({nm, "_b_hs"}, 32'(ok), 1);
  endtask

  task automatic axi_read(input vec_t v, input string nm,
                          output logic [3:0][31:0] d,
                          output logic [3:0][1:0] r,
                          output logic [3:0] l,
                          output logic [3:0][3:0] ids);
    bit ok;
    d = 'x; r = 'x; l = 'x; ids = 'x;
    s_axi.arid = v.id;
    s_axi.araddr = v.addr;
    s_axi.arlen = v.len;
    s_axi.arsize = v.size;
    s_axi.arburst = v.burst;
    s_axi.arvalid = 1'b1;
    ok = 0;
    for (int n = 0; n < 64; n++) begin
      if (s_axi.arready) begin ok = 1; tick(); break; end
      tick();
    end
    s_axi.arvalid = 1'b0;
    chk({nm, "_ar_hs"}, 32'(ok), 1);
    s_axi.rready = 1'b1;
    for (int i = 0; i <= int'(v.len); i++) begin
      ok = 0;
      for (int n = 0; n < 64; n++) begin
        if (s_axi.rvalid) begin
          ok = 1;
          d[i] = s_axi.rdata;
          r[i] = s_axi.rresp;
          l[i] = s_axi.rlast;
          ids[i] = s_axi.rid;
          tick();
          break;
        end
        tick();
      end
      if (!ok) chk($sformatf("%s_r%0d_hs", nm, i), 32'(ok), 1);
    end
    s_axi.rready = 1'b0;
  endtask

  initial begin
    logic [1:0] bresp;
    logic [3:0] bid;
    logic [3:0][31:0] d;
    logic [3:0][1:0] r;
    logic [3:0] l;
    logic [3:0][3:0] ids;
    string nm;

    vt[0]  = mkw(4'd3, 32'h10, 8'd3, 2'b01, 3'd2,
                 32'hA0, 4'hF, -1, 2'b00);
    vt[1]  = mkr(4'd5, 32'h10, 8'd3, 2'b01,
                 {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0);
    vt[2]  = mkw(4'd1, 32'h20, 8'd2, 2'b00, 3'd2,
                 32'h1, 4'hF, -1, 2'b00);
    vt[3]  = mkr(4'd2, 32'h20, 8'd0, 2'b01,
                 {96'h0, 32'h3}, '0);
    vt[4]  = mkw(4'd0, 32'h0, 8'd0, 2'b01, 3'd2,
                 32'hFFFFFFFF, 4'hF, -1, 2'b00);
    vt[5]  = mkw(4'd0, 32'h0, 8'd0, 2'b01, 3'd2,
                 32'h12345678, 4'b0101, -1, 2'b00);
    vt[6]  = mkr(4'd7, 32'h0, 8'd0, 2'b01,
                 {96'h0, STRB_EXP}, '0);
    vt[7]  = mkw(4'd9, 32'hFFC, 8'd1, 2'b01, 3'd2,
                 32'hBEEF0000, 4'hF, -1, 2'b10);
    vt[8]  = mkr(4'd9, 32'hFFC, 8'd1, 2'b01,
                 {64'h0, 32'h0, 32'hBEEF0000},
                 {2'b00, 2'b00, 2'b10, 2'b00});
    vt[9]  = mkw(4'd4, 32'h10, 8'd3, 2'b10, 3'd2,
                 32'h55, 4'hF, -1, 2'b10);
    vt[10] = mkr(4'd6, 32'h10, 8'd3, 2'b01,
                 {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0);
    vt[11] = mkw(4'd8, 32'h40, 8'd3, 2'b01, 3'd2,
                 32'h70, 4'hF, 1, 2'b10);
    vt[12] = mkr(4'd1, 32'h40, 8'd3, 2'b01,
                 {32'h73, 32'h72, 32'h71, 32'h70}, '0);
    vt[13] = mkw(4'd2, 32'h40, 8'd0, 2'b01, 3'd1,
                 32'h99, 4'hF, -1, 2'b10);
    vt[14] = mkr(4'd3, 32'h40, 8'd1, 2'b10,
                 '0, {2'b00, 2'b00, 2'b10, 2'b10});

    s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0;
    s_axi.awsize = '0; s_axi.awburst = '0; s_axi.awlock = '0;
    s_axi.awcache = '0; s_axi.awprot = '0; s_axi.awqos = '0;
    s_axi.awregion = '0; s_axi.awvalid = 1'b0;
    s_axi.wid = '0; s_axi.wdata = '0; s_axi.wstrb = '0;
    s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0;
    s_axi.arsize = '0; s_axi.arburst = '0; s_axi.arlock = '0;
    s_axi.arcache = '0; s_axi.arprot = '0; s_axi.arqos = '0;
    s_axi.arregion = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;

    tick();
    tick();
    chk("rst_awready", 32'(s_axi.awready), 0);
    chk("rst_arready", 32'(s_axi.arready), 0);
    chk("rst_bvalid", 32'(s_axi.bvalid), 0);
    chk("rst_rvalid", 32'(s_axi.rvalid), 0);
    chk("rst_wready", 32'(s_axi.wready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready_early", 32'(s_axi.awready), 0);
    tick();
    chk("post_rst_awready", 32'(s_axi.awready), 1);
    chk("post_rst_arready", 32'(s_axi.arready), 1);

    for (int k = 0; k < 15; k++) begin
      nm = $sformatf("v%0d", k);
      if (vt[k].wr) begin
        axi_write(vt[k], nm, bresp, bid);
        chk({nm, "_bresp"}, 32'(bresp), 32'(vt[k].exp_b));
        chk({nm, "_bid"}, 32'(bid), 32'(vt[k].id));
      end else begin
        axi_read(vt[k], nm, d, r, l, ids);
        for (int i = 0; i <= int'(vt[k].len); i++) begin
          chk($sformatf("%s_rdata%0d", nm, i), d[i], vt[k].exp_d[i]);
          chk($sformatf("%s_rresp%0d", nm, i),
              32'(r[i]), 32'(vt[k].exp_r[i]));
          chk($sformatf("%s_rlast%0d", nm, i),
              32'(l[i]), 32'(i == int'(vt[k].len)));
          chk($sformatf("%s_rid%0d", nm, i),
              32'(ids[i]), 32'(vt[k].id));
        end
      end
    end

    s_axi.awid = 4'd2; s_axi.awaddr = 32'h80; s_axi.awlen = 8'd0;
    s_axi.awsize = 3'd2; s_axi.awburst = 2'b01;
    s_axi.awvalid = 1'b1;
    chk("lat_awready", 32'(s_axi.awready), 1);
    tick();
    s_axi.awvalid = 1'b0;
    chk("lat_wready", 32'(s_axi.wready), 1);
    chk("lat_awready_busy", 32'(s_axi.awready), 0);
    s_axi.wdata = 32'h5A; s_axi.wstrb = 4'hF;
    s_axi.wlast = 1'b1; s_axi.wvalid = 1'b1;
    tick();
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    chk("lat_bvalid", 32'(s_axi.bvalid), 1);
    chk("lat_bresp", 32'(s_axi.bresp), 0);
    s_axi.bready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
    chk("lat_bvalid_clr", 32'(s_axi.bvalid), 0);

    s_axi.arid = 4'd6; s_axi.araddr = 32'h80; s_axi.arlen = 8'd0;
    s_axi.arsize = 3'd2; s_axi.arburst = 2'b01;
    s_axi.arvalid = 1'b1;
    tick();
    s_axi.arvalid = 1'b0;
    chk("lat_rvalid_fetch", 32'(s_axi.rvalid), 0);
    tick();
    chk("lat_rvalid", 32'(s_axi.rvalid), 1);
    chk("lat_rdata", s_axi.rdata, 32'h5A);
    tick();
    chk("hold_rvalid", 32'(s_axi.rvalid), 1);
    chk("hold_rdata", s_axi.rdata, 32'h5A);
    chk("hold_rid", 32'(s_axi.rid), 6);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_rvalid", 32'(s_axi.rvalid), 0);
    chk("abort_arready", 32'(s_axi.arready), 0);
    chk("abort_rdata", s_axi.rdata, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_arready_early", 32'(s_axi.arready), 0);
    tick();
    chk("abort_arready_up", 32'(s_axi.arready), 1);
    chk("abort_rvalid_idle", 32'(s_axi.rvalid), 0);

    vt[0] = mkr(4'd4, 32'h80, 8'd0, 2'b01, {96'h0, 32'h5A}, '0);
    axi_read(vt[0], "post_abort", d, r, l, ids);
    chk("post_abort_rdata", d[0], 32'h5A);
    chk("post_abort_rresp", 32'(r[0]), 0);
    chk("post_abort_rlast", 32'(l[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_mem_slave.md
# axi4_mem_slave

AXI4 memory-mapped slave endpoint backed by an internal dual-port word memory. Terminates an `ifc_axi4` link on its `slave` modport: accepts INCR and FIXED bursts on independent read and write paths and returns OKAY/SLVERR responses. It serves as the downstream consumer of the AXI4 bus in simulation testbenches and small on-chip scratchpads.

## Interface
- ADDR_WIDTH, 32, byte address width; must match the bound interface.
- DATA_WIDTH, 32, data width; one of 8..1024 in powers of two. STRB_WIDTH = DATA_WIDTH/8.
- ID_WIDTH, 4, transaction ID width; must match the interface.
- MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_axi  ifc_axi4.slave  —  full AXI4 slave port.
  - Driven: awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid.
  - All other signals are inputs.
  - buser and ruser are tied to 0.
  - awlock, awcache, awprot, awqos, awregion, wid and the ar* equivalents are ignored.
  - The interface's own rst_n is unused.

## Operation
- Word index = addr >> log2(STRB_WIDTH). A beat is in range iff the word index < MEM_DEPTH.
- Memory contents are not reset.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready=1. On AW handshake, capture awid, awaddr, awlen, awsize and awburst; clear the error flag; beat counter := 0; go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write in-range beats under strobe and drop out-of-range beats (error flag set).
    - Address advance: INCR adds STRB_WIDTH; FIXED holds the address.
    - Leaving W_DATA: after beat awlen+1, go to W_RESP. The burst ends on the count, not on wlast.
    - wlast mismatch: wlast≠(counter==awlen) on any beat sets the error flag.
  - W_RESP: bvalid=1, bid = captured awid, bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until bready, then go to W_IDLE.
  - Whole-burst errors: awburst=WRAP or reserved, or awsize≠log2(STRB_WIDTH). All beats are consumed, no memory writes occur, and bresp=SLVERR.
- Read FSM: R_IDLE → R_FETCH → R_DATA → (R_FETCH or R_IDLE).
  - R_IDLE: arready=1. On AR handshake, capture the AR fields and go to R_FETCH.
  - R_FETCH: register mem[word index] into rdata; out-of-range reads give 0. Go to R_DATA.
  - R_DATA: rvalid=1, rid = captured arid, rresp per beat (SLVERR if out of range or on a whole-burst error), rlast = (counter==arlen).
    - On R handshake: if last, go to R_IDLE; else advance the address (INCR/FIXED) and go to R_FETCH.
  - Whole-burst read errors (WRAP/reserved burst or bad size): every beat returns rdata=0 and rresp=SLVERR, with arlen+1 beats still delivered.
- Read and write paths are fully independent and may run concurrently.
- Same-word collision: a write and an R_FETCH in the same cycle make the read return the old data.

## Timing
- While rst is high, all driven outputs are 0 and both FSMs are in IDLE.
- awready and arready rise on the first clk edge after rst falls.
- Reset mid-burst aborts immediately: no further memory writes occur, and pending B/R responses are discarded.
- AW accepted at edge N: wready=1 from N+1. One write beat per cycle at most.
- Last W beat accepted at edge M: bvalid=1 from M+1.
- AR accepted at edge N: the first rvalid is at N+2. Each following beat has rvalid two cycles after the previous R handshake, so peak throughput is one beat per 2 cycles.
- awready=0 outside W_IDLE and arready=0 outside R_IDLE; there is one outstanding transaction per direction.
- bvalid, rvalid and all payload outputs are registered and stable while valid is high and ready is low.

## Configuration
- AXI4_MEM_SLAVE_WSTRB_EN defined: each byte lane is written only when its wstrb bit is 1; wstrb=0 writes nothing but still counts as a beat.
- AXI4_MEM_SLAVE_WSTRB_EN undefined: wstrb is ignored, and every accepted in-range beat writes the full word.

## Test plan
- INCR write awaddr=0x10, awlen=3, data 0xA0..0xA3, then INCR read of the same range → bresp=OKAY; rdata=0xA0,0xA1,0xA2,0xA3 with rlast only on the 4th beat; rid=arid.
- FIXED write awaddr=0x20, awlen=2, data 1,2,3, then single-beat read at 0x20 → rdata=3, rresp=OKAY.
- With WSTRB_EN: write 0xFFFFFFFF to 0x0, then write 0x12345678 with wstrb=4'b0101 → readback 0xFF34FF78. Without WSTRB_EN → readback 0x12345678.
- INCR write starting at word MEM_DEPTH-1, awlen=1 → word MEM_DEPTH-1 written; bresp=SLVERR. The matching read returns rresp OKAY then SLVERR, with the 2nd beat rdata=0.
- Error bursts: awburst=WRAP, awlen=3 → 4 beats accepted, memory unchanged, bresp=SLVERR. Early wlast on beat 1 of 4 → all 4 beats are still accepted and bresp=SLVERR.
- Assert rst during R_DATA with rready=0 → rvalid=0 immediately. arready=1 after the first edge post-reset; a new read returns the correct data.
